seg_display_mux: RTL
====================

SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000: CLK cycles per digit slot; legal range 4..2^20.
REQ-002 SHALL have parameter DEAD_CYC, default 64: all-anodes-off cycles at the start of each slot; legal range 1..REFRESH_DIV-2.
REQ-003 SHALL have port CLK, input, 1: single clock, rising edge.
REQ-004 SHALL have port RST_N, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port LD, input, 1: load strobe; N2/N1 sampled when high.
REQ-006 SHALL have port N2, input, 4: tens BCD digit from the BCD converter stage.
REQ-007 SHALL have port N1, input, 4: units BCD digit from the BCD converter stage.
REQ-008 SHALL have port BLANK_LZ, input, 1: suppress tens digit when latched tens equals 0.
REQ-009 SHALL have port SEG, output, 7: segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-010 SHALL have port AN, output, 2: digit enables, active-low; AN[0] is units, AN[1] is tens.
REQ-011 SHALL have port ACK, output, 1: one-cycle pulse confirming a load.

Function
REQ-012 SHALL capture N2 and N1 into holding registers D2 and D1 on every rising edge where LD=1, and hold them otherwise.
REQ-013 SHALL assert ACK for exactly one cycle after each edge with LD=1; LD held high for n cycles SHALL give n ACK cycles.
REQ-014 SHALL run a refresh counter CNT from 0 to REFRESH_DIV-1, wrapping to 0.
REQ-015 SHALL toggle the digit selector DIG on each wrap of CNT; DIG=0 selects units and DIG=1 selects tens.
REQ-016 SHALL register SEG and AN; both outputs reflect the state of CNT, DIG, D2 and D1 as it was one edge earlier.
REQ-017 SHALL drive AN=2'b11 and SEG=7'h7F while CNT < DEAD_CYC (ghosting dead band).
REQ-018 SHALL drive AN=2'b10 with units encoding when CNT >= DEAD_CYC and DIG=0, and AN=2'b01 with tens encoding when DIG=1.
REQ-019 SHALL encode active-low SEG as: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
REQ-020 SHALL encode digit codes 10..15 as dash (SEG=7'h3F), treated as an upstream error indication.
REQ-021 SHALL, in the tens slot with BLANK_LZ=1 and D2=0, drive AN=2'b11 and SEG=7'h7F; the units digit is never blanked.
REQ-022 SHALL, when LD and a CNT wrap occur on the same edge, perform both actions; the new slot displays the newly latched data.
REQ-023 SHALL make a load visible on SEG no later than 2 edges after the LD edge when the affected digit is active and outside the dead band.
REQ-024 SHALL sample BLANK_LZ every cycle without latching it.

Reset
REQ-025 SHALL, on an edge with RST_N=0, set D2=0, D1=0, CNT=0, DIG=0, ACK=0, AN=2'b11 and SEG=7'h7F.
REQ-026 SHALL give reset priority over LD on the same edge; the load is discarded and no ACK is produced.
REQ-027 SHALL restart the scan from CNT=0, DIG=0 with the dead band first when reset is released mid-slot.

Structure
REQ-028 SHALL place the segment code constants (digits 0..9, DASH=7'h3F, BLANK=7'h7F) in the shared display package.
REQ-029 SHALL place the combinational digit-to-segment encoder in one sub-module, seg7_encoder: 4-bit input, 7-bit active-low output.
REQ-030 SHALL size CNT as clog2(REFRESH_DIV) bits; comparisons SHALL be unsigned with no truncation at REFRESH_DIV-1.

Verification (REFRESH_DIV=8, DEAD_CYC=1 unless stated)
REQ-031 SHALL check reset: RST_N=0 for 3 cycles with LD=1, N2=3, N1=4 -> AN=11, SEG=7F, ACK=0; after release, first units slot shows SEG=40.
REQ-032 SHALL check load and scan: LD pulse with N2=1, N1=7 -> ACK one cycle; units slot AN=10, SEG=78; tens slot AN=01, SEG=79; period 16 cycles; 1 dead cycle per slot.
REQ-033 SHALL check blanking: load N2=0, N1=5 with BLANK_LZ=1 -> tens slot AN=11; with BLANK_LZ=0 -> tens slot AN=01, SEG=40.
REQ-034 SHALL check invalid code: load N2=12, N1=15 -> both slots SEG=3F.
REQ-035 SHALL check simultaneous events: LD asserted on the CNT=7 wrap edge with N2=9 -> the following tens slot shows SEG=10 and ACK is seen.
REQ-036 SHALL check sweep: feed all 32 converter outputs (values 0..31) -> every digit pair displays correctly; no cycle has AN=00.

Source files
------------

// File: rtl/seg_display_mux_pkg.sv
// Shared constants for the two-digit seven-segment display multiplexer:
// active-low segment codes ({g,f,e,d,c,b,a}), anode patterns and the digit selector type.
package seg_display_mux_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] AN_OFF    = 2'b11;
    localparam logic [1:0] AN_UNITS  = 2'b10;
    localparam logic [1:0] AN_TENS   = 2'b01;

    typedef enum logic {
        DIG_UNITS = 1'b0,
        DIG_TENS  = 1'b1
    } digit_sel_e;

endpackage

// File: rtl/seg7_encoder.sv
// Combinational BCD-to-seven-segment encoder, active-low outputs.
// Codes 10..15 show a dash so upstream conversion errors stay visible.
module seg7_encoder
    import seg_display_mux_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_display_mux.sv
// Two-digit multiplexed seven-segment driver: latches BCD digits on LD, scans
// units/tens slots with an all-off dead band at the start of each slot.
module seg_display_mux
    import seg_display_mux_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYC    = 64
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       LD,
    input  logic [3:0] N2,
    input  logic [3:0] N1,
    input  logic       BLANK_LZ,
    output logic [6:0] SEG,
    output logic [1:0] AN,
    output logic       ACK
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYC);

    logic [3:0]       d2;
    logic [3:0]       d1;
    logic [CNT_W-1:0] cnt;
    digit_sel_e       dig;

    logic [3:0] active_code;
    logic [6:0] active_seg;
    logic [6:0] next_seg;
    logic [1:0] next_an;

    assign active_code = (dig == DIG_TENS) ? d2 : d1;

    seg7_encoder u_encoder (
        .code (active_code),
        .seg  (active_seg)
    );

    // Output decision uses the pre-edge scan state, so SEG/AN lag CNT by one edge.
    always_comb begin
        next_seg = SEG_BLANK;
        next_an  = AN_OFF;
        if (cnt >= CNT_DEAD) begin
            if (dig == DIG_UNITS) begin
                next_seg = active_seg;
                next_an  = AN_UNITS;
            end else if (!(BLANK_LZ && d2 == 4'd0)) begin
                next_seg = active_seg;
                next_an  = AN_TENS;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            d2  <= 4'd0;
            d1  <= 4'd0;
            cnt <= '0;
            dig <= DIG_UNITS;
            ACK <= 1'b0;
            SEG <= SEG_BLANK;
            AN  <= AN_OFF;
        end else begin
            if (LD) begin
                d2 <= N2;
                d1 <= N1;
            end
            ACK <= LD;
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                dig <= (dig == DIG_UNITS) ? DIG_TENS : DIG_UNITS;
            end else begin
                cnt <= cnt + 1'b1;
            end
            SEG <= next_seg;
            AN  <= next_an;
        end
    end

endmodule
